// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built from a single 4-bit slice, one nibble per clock, LSB first.
// A start/busy/done handshake sequences the operation through IDLE, RUN and DONE.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               accept;
    logic               last;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [4:0]         slice_sum;

    // DONE accepts a new request just like IDLE, giving back-to-back operation.
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last      = (idx == IDX_W'(NIBBLES - 1));
    assign a_nib     = op_a[4*idx +: 4];
    assign b_nib     = op_b[4*idx +: 4];
    assign slice_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: assign a default before the case so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is cleared by the asynchronous reset, operands included, so an aborted add leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            sum   <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[4*idx +: 4] <= slice_sum[3:0];
            carry           <= slice_sum[4];
            if (last) begin
                cout <= slice_sum[4];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl with NIBBLES=4.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    int checks = 0;
    int errors = 0;
    logic last_cout = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called on a falling edge while the DUT is in IDLE or DONE; returns on the
    // falling edge of the DONE cycle. Optionally pokes start during RUN.
    task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_val,
                           input logic [15:0] es, input logic ec,
                           input bit inject, input string tag);
        int  busy_n = 0;
        int  lat    = 0;
        bit  seen   = 0;
        start = 1'b1;
        a     = ta;
        b     = tb_val;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_sum_clr"}, 32'(sum), 32'h0);
        check({tag, "_cout_hold"}, 32'(cout), 32'(last_cout));
        for (int n = 1; n <= 20 && !seen; n++) begin
            if (n > 1) @(negedge clk);
            if (inject && n == 2) begin
                start = 1'b1;
                a     = 16'hAAAA;
                b     = 16'hAAAA;
            end
            if (inject && n == 3) begin
                start = 1'b0;
                a     = 16'h5555;
            end
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
                lat  = n;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_lat"}, 32'(lat), 32'd5);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        last_cout = ec;
    endtask

    // Step one cycle from DONE into IDLE and confirm the pulse ended and results hold.
    task automatic idle_after(input logic [15:0] es, input logic ec, input string tag);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_sum_hold"}, 32'(sum), 32'(es));
        check({tag, "_cout_hold_idle"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_n;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_add(16'h1234, 16'h4321, 16'h5555, 1'b0, 0, "basic");
        idle_after(16'h5555, 1'b0, "basic");
        run_add(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0, "ripple");
        idle_after(16'h0000, 1'b1, "ripple");
        run_add(16'h8000, 16'h8000, 16'h0000, 1'b1, 0, "msb_carry");
        idle_after(16'h0000, 1'b1, "msb_carry");
        run_add(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 0, "to_msb");
        idle_after(16'h8000, 1'b0, "to_msb");
        run_add(16'hABCD, 16'h1234, 16'hBE01, 1'b0, 0, "mixed");
        idle_after(16'hBE01, 1'b0, "mixed");

        run_add(16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1, "ignore");
        @(negedge clk);
        check("ignore_no_second_done", 32'(done), 32'd0);
        check("ignore_no_restart", 32'(busy), 32'd0);
        @(negedge clk);

        run_add(16'h0001, 16'h0001, 16'h0002, 1'b0, 0, "b2b_first");
        run_add(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 0, "b2b_second");
        idle_after(16'hFFFE, 1'b1, "b2b_second");

        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h4321;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_partial_sum", 32'(sum), 32'h0055);
        check("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy_clr", 32'(busy), 32'd0);
        check("abort_done_clr", 32'(done), 32'd0);
        check("abort_sum_clr", 32'(sum), 32'h0);
        check("abort_cout_clr", 32'(cout), 32'd0);
        #2;
        rst_n = 1'b1;
        last_cout = 1'b0;
        done_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("post_reset_idle", 32'(done_n), 32'd0);
        run_add(16'h0010, 16'h0020, 16'h0030, 1'b0, 0, "post_reset");
        idle_after(16'h0030, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
